// File: rtl/microwave_timer_ctrl.sv
//------------------------------------------------------------------------------
// microwave_timer_ctrl
//
// Purpose:
//   Microwave oven cook timer. Digits are entered on a 10-key keypad and shift
//   in from the right. Start begins a countdown while the door is closed. Stop
//   pauses the countdown, and a second stop clears it. Opening the door also
//   pauses. At 0:00 the controller returns to idle and pulses done for one
//   cycle. The time is shown on 7-segment displays (active-high, bit0=a ..
//   bit6=g) with no blanking.
//
// Parameters:
//   TICKS_PER_SEC : clock cycles per countdown second (2..65535)
//   MIN_DIGITS    : number of minutes digits (1..3)
//
// Ports:
//   clock         : system clock, rising-edge active
//   clearn        : asynchronous active-low reset
//   startn        : start/resume button, active-low
//   stopn         : stop/clear button, active-low
//   door_closed   : 1 = door closed
//   keypad[9:0]   : bit k = digit key k pressed
//   power_level   : [3:0] duty level 0..10 (values above 10 count as 10),
//                   present only with POWER_LEVEL_EN
//   mag_on        : magnetron enable (registered)
//   done          : one-cycle pulse when cooking completes
//   sec_ones_segs : seconds-ones display
//   sec_tens_segs : seconds-tens display
//   mins_segs     : minutes displays, least-significant digit in bits [6:0]
//
// Configuration macro:
//   POWER_LEVEL_EN : adds the power_level input. mag_on then follows a duty
//                    cycle within each second while cooking. Without it,
//                    mag_on is high for the whole time the timer is cooking.
//------------------------------------------------------------------------------
module microwave_timer_ctrl #(
   parameter int TICKS_PER_SEC = 100,
   parameter int MIN_DIGITS    = 1
) (
   input  logic                      clock,
   input  logic                      clearn,
   input  logic                      startn,
   input  logic                      stopn,
   input  logic                      door_closed,
   input  logic [9:0]                keypad,
`ifdef POWER_LEVEL_EN
   input  logic [3:0]                power_level,
`endif
   output logic                      mag_on,
   output logic                      done,
   output logic [6:0]                sec_ones_segs,
   output logic [6:0]                sec_tens_segs,
   output logic [7*MIN_DIGITS-1:0]   mins_segs
);

   // Digit order in the packed time vector (4 bits per BCD digit):
   //   [3:0] sec_ones, [7:4] sec_tens, [11:8] mins[0], ... up to the top minute.
   localparam int ND = MIN_DIGITS + 2;
   localparam int DW = 4 * ND;

   localparam logic [15:0] PRESC_MAX = 16'(TICKS_PER_SEC - 1);
   localparam logic [31:0] TPS32     = 32'(TICKS_PER_SEC);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      COOK  = 2'd1,
      PAUSE = 2'd2
   } state_t;

   //---------------------------------------------------------------------------
   // 7-segment encoder, active-high, bit0=a .. bit6=g
   //---------------------------------------------------------------------------
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b0111111;  // non-BCD codes cannot be entered
      endcase
      return s;
   endfunction

   //---------------------------------------------------------------------------
   // One-second decrement with borrow. sec_tens wraps 0 -> 5. All other digits
   // wrap 0 -> 9. sec_tens values 6..9 typed on the keypad are not
   // normalised, so 0:99 counts to 0:98. The caller never passes all-zero.
   //---------------------------------------------------------------------------
   function automatic logic [DW-1:0] dec_time(input logic [DW-1:0] t);
      logic [DW-1:0] r;
      logic          borrow;
      r      = t;
      borrow = 1'b1;
      for (int i = 0; i < ND; i++) begin
         if (borrow) begin
            if (r[4*i +: 4] == 4'd0) begin
               r[4*i +: 4] = (i == 1) ? 4'd5 : 4'd9;
            end else begin
               r[4*i +: 4] = r[4*i +: 4] - 4'd1;
               borrow      = 1'b0;
            end
         end
      end
      return r;
   endfunction

   //---------------------------------------------------------------------------
   // State
   //---------------------------------------------------------------------------
   state_t          state_q,  state_d;
   logic [DW-1:0]   digits_q, digits_d;
   logic [15:0]     presc_q,  presc_d;
   logic            start_seen_q, start_seen_d;
   logic            stop_seen_q,  stop_seen_d;
   logic [9:0]      keypad_q, keypad_d;
   logic            mag_on_q, mag_on_d;
   logic            done_q,   done_d;

   // Edge-detect and key decode
   logic            start_ev;
   logic            stop_ev;
   logic [9:0]      new_keys;
   logic            key_hit;
   logic [3:0]      key_val;
   logic [DW-1:0]   dec_val;

`ifdef POWER_LEVEL_EN
   logic [3:0]      power_clamped;
`endif

   always_comb begin
      start_ev = ~startn & ~start_seen_q;
      stop_ev  = ~stopn  & ~stop_seen_q;
      new_keys = keypad & ~keypad_q;

      // Scan from the top down so the lowest newly pressed key wins.
      key_hit = 1'b0;
      key_val = 4'd0;
      for (int k = 9; k >= 0; k--) begin
         if (new_keys[k]) begin
            key_hit = 1'b1;
            key_val = 4'(k);
         end
      end

      dec_val = dec_time(digits_q);
   end

   //---------------------------------------------------------------------------
   // Next-state logic
   //---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      digits_d     = digits_q;
      presc_d      = presc_q;
      done_d       = 1'b0;
      start_seen_d = ~startn;
      stop_seen_d  = ~stopn;
      keypad_d     = keypad;

      case (state_q)
         IDLE: begin
            // Stop takes priority over start. In idle it acts as a clear.
            if (stop_ev) begin
               digits_d = '0;
            end else if (start_ev && door_closed && (digits_q != '0)) begin
               state_d = COOK;
               presc_d = '0;
            end else if (key_hit) begin
               // Shift left by one digit. The top minutes digit falls off.
               digits_d = {digits_q[DW-5:0], key_val};
            end
         end

         COOK: begin
            if (stop_ev || !door_closed) begin
               state_d = PAUSE;
            end else if (presc_q == PRESC_MAX) begin
               presc_d  = '0;
               digits_d = dec_val;
               if (dec_val == '0) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               presc_d = presc_q + 16'd1;
            end
         end

         PAUSE: begin
            if (stop_ev) begin
               state_d  = IDLE;
               digits_d = '0;
               presc_d  = '0;
            end else if (start_ev && door_closed) begin
               // Resume mid-second. The prescaler keeps its value.
               state_d = COOK;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

`ifdef POWER_LEVEL_EN
      power_clamped = (power_level > 4'd10) ? 4'd10 : power_level;
      // Duty cycle within each second: on while presc/TPS < level/10.
      mag_on_d = (state_d == COOK) &&
                 ((32'(presc_d) * 32'd10) < (32'(power_clamped) * TPS32));
`else
      mag_on_d = (state_d == COOK);
`endif
   end

   //---------------------------------------------------------------------------
   // Registers
   //---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge clearn) begin
      if (!clearn) begin
         state_q      <= IDLE;
         digits_q     <= '0;
         presc_q      <= '0;
         start_seen_q <= 1'b0;
         stop_seen_q  <= 1'b0;
         keypad_q     <= '0;
         mag_on_q     <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         digits_q     <= digits_d;
         presc_q      <= presc_d;
         start_seen_q <= start_seen_d;
         stop_seen_q  <= stop_seen_d;
         keypad_q     <= keypad_d;
         mag_on_q     <= mag_on_d;
         done_q       <= done_d;
      end
   end

   //---------------------------------------------------------------------------
   // Outputs
   //---------------------------------------------------------------------------
   assign mag_on        = mag_on_q;
   assign done          = done_q;
   assign sec_ones_segs = seg7(digits_q[3:0]);
   assign sec_tens_segs = seg7(digits_q[7:4]);

   for (genvar g = 0; g < MIN_DIGITS; g++) begin : g_mins
      assign mins_segs[7*g +: 7] = seg7(digits_q[8 + 4*g +: 4]);
   end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
module tb_microwave_timer_ctrl;

   localparam int T  = 100;
   localparam int MD = 1;

   logic           clock       = 1'b0;
   logic           clearn      = 1'b1;
   logic           startn      = 1'b1;
   logic           stopn       = 1'b1;
   logic           door_closed = 1'b1;
   logic [9:0]     keypad      = '0;
`ifdef POWER_LEVEL_EN
   logic [3:0]     power_level = 4'd10;
`endif
   logic           mag_on;
   logic           done;
   logic [6:0]     sec_ones_segs;
   logic [6:0]     sec_tens_segs;
   logic [7*MD-1:0] mins_segs;

   microwave_timer_ctrl #(.TICKS_PER_SEC(T), .MIN_DIGITS(MD)) dut (
      .clock         (clock),
      .clearn        (clearn),
      .startn        (startn),
      .stopn         (stopn),
      .door_closed   (door_closed),
      .keypad        (keypad),
`ifdef POWER_LEVEL_EN
      .power_level   (power_level),
`endif
      .mag_on        (mag_on),
      .done          (done),
      .sec_ones_segs (sec_ones_segs),
      .sec_tens_segs (sec_tens_segs),
      .mins_segs     (mins_segs)
   );

   always #5 clock = ~clock;

   typedef struct {
      string      name;
      logic [3:0] m;
      logic [3:0] t;
      logic [3:0] o;
      logic       mag;
      logic       dn;
   } exp_t;

   exp_t sb_q[$];
   exp_t e;
   int   checks    = 0;
   int   errors    = 0;
   int   done_seen = 0;

   // Reference segment table (active-high, bit0=a .. bit6=g)
   function automatic logic [6:0] seg(input logic [3:0] d);
      case (d)
         4'd0: return 7'b0111111;
         4'd1: return 7'b0000110;
         4'd2: return 7'b1011011;
         4'd3: return 7'b1001111;
         4'd4: return 7'b1100110;
         4'd5: return 7'b1101101;
         4'd6: return 7'b1111101;
         4'd7: return 7'b0000111;
         4'd8: return 7'b1111111;
         4'd9: return 7'b1101111;
         default: return 7'b0000000;
      endcase
   endfunction

   task automatic expect_disp(input string name, input int m, input int t, input int o,
                              input logic mag, input logic dn);
      exp_t x;
      x.name = name; x.m = 4'(m); x.t = 4'(t); x.o = 4'(o); x.mag = mag; x.dn = dn;
      sb_q.push_back(x);
   endtask

   // Monitor: compares every queued expectation against the DUT outputs at the
   // falling edge that follows it.
   always @(negedge clock) begin
      if (done === 1'b1) done_seen++;
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checks++;
         if (mins_segs !== seg(e.m) || sec_tens_segs !== seg(e.t) ||
             sec_ones_segs !== seg(e.o) || mag_on !== e.mag || done !== e.dn) begin
            errors++;
            $display("FAIL %s: got m=%b t=%b o=%b mag_on=%b done=%b, expected m=%b t=%b o=%b mag_on=%b done=%b",
                     e.name, mins_segs, sec_tens_segs, sec_ones_segs, mag_on, done,
                     seg(e.m), seg(e.t), seg(e.o), e.mag, e.dn);
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic press_key(input int k);
      keypad = 10'd1 << k;
      tick(1);
      keypad = '0;
      tick(1);
   endtask

   task automatic press_start();
      startn = 1'b0; tick(1); startn = 1'b1; tick(1);
   endtask

   task automatic press_stop();
      stopn = 1'b0; tick(1); stopn = 1'b1; tick(1);
   endtask

   task automatic press_both();
      startn = 1'b0; stopn = 1'b0; tick(1); startn = 1'b1; stopn = 1'b1; tick(1);
   endtask

`ifdef POWER_LEVEL_EN
   task automatic check_duty(input string name, input int want);
      int cnt;
      cnt = 0;
      for (int i = 0; i < T; i++) begin
         tick(1);
         if (mag_on === 1'b1) cnt++;
      end
      checks++;
      if (cnt != want) begin
         errors++;
         $display("FAIL %s: mag_on high %0d of %0d cycles, expected %0d", name, cnt, T, want);
      end
   endtask
`endif

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset
      #2 clearn = 1'b0;
      #1 expect_disp("reset", 0, 0, 0, 0, 0);
      tick(2);
      clearn = 1'b1;
      tick(1);

      // Keypad entry 2,5,9 -> 2:59
      press_key(2);  expect_disp("key_2", 0, 0, 2, 0, 0);
      press_key(5);
      press_key(9);  expect_disp("keys_259", 2, 5, 9, 0, 0);

      // Cook one second
      press_start;   expect_disp("start_cook", 2, 5, 9, 1, 0);
      tick(98);      expect_disp("before_first_sec", 2, 5, 9, 1, 0);
      tick(1);       expect_disp("first_sec_258", 2, 5, 8, 1, 0);

      // Pause half-way through a second, then resume from the held prescaler
      tick(50);
      press_stop;    expect_disp("stop_pause", 2, 5, 8, 0, 0);
      tick(200);     expect_disp("pause_frozen", 2, 5, 8, 0, 0);
      press_start;   expect_disp("resume", 2, 5, 8, 1, 0);
      tick(48);      expect_disp("resume_before_sec", 2, 5, 8, 1, 0);
      tick(1);       expect_disp("resume_sec_257", 2, 5, 7, 1, 0);

      // Stop twice clears; start on 0:00 ignored
      press_stop;    expect_disp("stop_once", 2, 5, 7, 0, 0);
      press_stop;    expect_disp("stop_twice_clear", 0, 0, 0, 0, 0);
      press_start;   expect_disp("start_zero_ignored", 0, 0, 0, 0, 0);

      // 1:00 -> 0:59, then the door interlock
      press_key(1); press_key(0); press_key(0);
      expect_disp("keys_100", 1, 0, 0, 0, 0);
      press_start;
      tick(98);      expect_disp("before_059", 1, 0, 0, 1, 0);
      tick(1);       expect_disp("borrow_059", 0, 5, 9, 1, 0);
      door_closed = 1'b0;
      tick(1);       expect_disp("door_open_pause", 0, 5, 9, 0, 0);
      press_start;   expect_disp("start_door_open", 0, 5, 9, 0, 0);
      door_closed = 1'b1;
      tick(3);       expect_disp("door_closed_stays_paused", 0, 5, 9, 0, 0);
      press_start;   expect_disp("door_resume", 0, 5, 9, 1, 0);
      press_stop; press_stop;
      expect_disp("clear_after_door", 0, 0, 0, 0, 0);

      // 0:01 -> done pulse
      press_key(1);
      press_start;
      tick(98);      expect_disp("before_done", 0, 0, 1, 1, 0);
      tick(1);       expect_disp("done_pulse", 0, 0, 0, 0, 1);
      tick(1);       expect_disp("done_one_cycle", 0, 0, 0, 0, 0);

      // Top minutes digit discarded: 1,0,0,0 -> 0:00
      press_key(1); press_key(0); press_key(0); press_key(0);
      expect_disp("top_digit_discard", 0, 0, 0, 0, 0);

      // 0:99 -> 0:98
      press_key(9); press_key(9);
      expect_disp("keys_099", 0, 9, 9, 0, 0);
      press_start;
      tick(99);      expect_disp("tens_gt5_098", 0, 9, 8, 1, 0);
      press_stop; press_stop;

      // Several keys at once -> lowest; held keys do not repeat
      keypad = 10'b10_0010_1000;
      tick(1);       expect_disp("multi_key_lowest", 0, 0, 3, 0, 0);
      keypad = 10'b10_0010_1010;
      tick(1);       expect_disp("only_new_key", 0, 3, 1, 0, 0);
      tick(3);       expect_disp("held_no_repeat", 0, 3, 1, 0, 0);
      keypad = '0;
      tick(1);

      // Simultaneous start+stop resolves as stop
      press_start;   expect_disp("cook_031", 0, 3, 1, 1, 0);
      press_both;    expect_disp("both_in_cook", 0, 3, 1, 0, 0);
      press_both;    expect_disp("both_in_pause", 0, 0, 0, 0, 0);

      // Keypad ignored in COOK and PAUSE
      press_key(7);  expect_disp("key_idle_7", 0, 0, 7, 0, 0);
      press_start;
      press_key(3);  expect_disp("key_ignored_cook", 0, 0, 7, 1, 0);
      press_stop;
      press_key(4);  expect_disp("key_ignored_pause", 0, 0, 7, 0, 0);
      press_stop;    expect_disp("clear_again", 0, 0, 0, 0, 0);

      // Asynchronous reset mid-COOK
      press_key(5);
      press_start;
      tick(10);
      #1 clearn = 1'b0;
      #1 expect_disp("async_reset_mid_cook", 0, 0, 0, 0, 0);
      tick(2);
      clearn = 1'b1;
      tick(1);       expect_disp("after_reset", 0, 0, 0, 0, 0);
      press_start;   expect_disp("start_after_reset_ignored", 0, 0, 0, 0, 0);

`ifdef POWER_LEVEL_EN
      power_level = 4'd5;
      press_key(5);
      press_start;
      check_duty("power_5", 50);
      power_level = 4'd12;
      check_duty("power_12", 100);
      press_stop; press_stop;
      power_level = 4'd10;
`endif

      tick(2);
      checks++;
      if (sb_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
      checks++;
      if (done_seen != 1) begin
         errors++;
         $display("FAIL done_count: saw %0d done cycles, expected 1", done_seen);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/microwave_timer_ctrl.md
MICROWAVE_TIMER_CTRL -- requirements
Module: microwave_timer_ctrl

Interface
REQ-001 Parameter TICKS_PER_SEC, default 100, meaning clock cycles per countdown second (range 2..65535).
REQ-002 Parameter MIN_DIGITS, default 1, meaning number of minutes digits (range 1..3).
REQ-003 Port clock, input, 1, meaning the single system clock; all state changes occur on its rising edge.
REQ-004 Port clearn, input, 1, meaning reset; asynchronous, active-low.
REQ-005 Port startn, input, 1, meaning start/resume button, active-low.
REQ-006 Port stopn, input, 1, meaning stop/clear button, active-low.
REQ-007 Port door_closed, input, 1, meaning 1 = door closed.
REQ-008 Port keypad, input, 10, meaning bit k = digit k key pressed.
REQ-009 Port mag_on, output, 1, meaning magnetron enable.
REQ-010 Port done, output, 1, meaning single-cycle pulse when cooking completes.
REQ-011 Port sec_ones_segs, output, 7, meaning seconds-ones display.
REQ-012 Port sec_tens_segs, output, 7, meaning seconds-tens display.
REQ-013 Port mins_segs, output, 7*MIN_DIGITS, meaning minutes displays, least-significant digit in bits [6:0].

Function
REQ-014 Display encoding SHALL be active-high segments with bit0=a through bit6=g (0=0111111, 2=1011011, 5=1101101, 8=1111111, 9=1101111); no blanking.
REQ-015 startn, stopn and any keypad bit SHALL be edge-detected: an action fires once, at the first rising edge where the input is asserted and the previous registered sample was deasserted.
REQ-016 Multiple keypad bits newly asserted in one cycle SHALL resolve to the lowest index.
REQ-017 State machine SHALL have states IDLE, COOK, PAUSE.
REQ-018 IDLE: key event shifts digits left (new digit into sec_ones, sec_ones->sec_tens, sec_tens->mins[0], mins[i]->mins[i+1]); top minutes digit discarded.
REQ-019 IDLE: start event with door_closed=1 and nonzero time SHALL go to COOK and clear the prescaler; otherwise start is ignored.
REQ-020 COOK: prescaler counts 0..TICKS_PER_SEC-1; at TICKS_PER_SEC-1 time decrements by one second.
REQ-021 Decrement borrow: sec_ones 0 -> 9 with sec_tens decrement; sec_tens 0 -> 5 with minutes decrement; entered sec_tens values 6..9 count down unchanged (0:99 -> 0:98).
REQ-022 COOK: time reaching all-zero SHALL go to IDLE with done=1 for exactly that one cycle.
REQ-023 COOK: stop event or door_closed=0 SHALL go to PAUSE; prescaler and digits hold.
REQ-024 PAUSE: start event with door_closed=1 SHALL return to COOK without clearing the prescaler; a stop event clears all digits and goes to IDLE.
REQ-025 Keypad SHALL be ignored in COOK and PAUSE.
REQ-026 Simultaneous start and stop events SHALL be resolved as stop.
REQ-027 mag_on SHALL be a registered output, 0 in IDLE and PAUSE; its COOK behaviour is set by REQ-030/031.

Reset
REQ-028 clearn=0 SHALL immediately force IDLE, all digits 0, prescaler 0, edge-detect samples deasserted, mag_on=0 and done=0, including mid-COOK.
REQ-029 On reset, all display outputs SHALL show 0 (0111111).

Configuration
REQ-030 With POWER_LEVEL_EN defined, input power_level[3:0] SHALL be added (values >10 treated as 10), and in COOK mag_on=1 only when prescaler*10 < power_level*TICKS_PER_SEC; power_level=0 keeps mag_on=0 while the timer still counts.
REQ-031 Without POWER_LEVEL_EN, the power_level port SHALL be absent and mag_on SHALL equal (state==COOK).

Verification (TICKS_PER_SEC=100, MIN_DIGITS=1)
REQ-032 Reset, keys 2,5,9 -> mins_segs=1011011, sec_tens_segs=1101101, sec_ones_segs=1101111, mag_on=0.
REQ-033 From 2:59, start with door closed -> mag_on=1; 100 cycles later the display shows 2:58.
REQ-034 Stop in COOK -> mag_on=0 and the display freezes; start -> the countdown resumes from the held prescaler; stop twice -> 0:00 and IDLE.
REQ-035 door_closed=0 mid-COOK -> PAUSE; start while the door is open is ignored; close the door and start -> COOK.
REQ-036 Cook 1:00 -> 0:59 after 100 cycles; from 0:01, the end of that second -> done for 1 cycle, mag_on=0, IDLE.
REQ-037 POWER_LEVEL_EN with power_level=5 -> mag_on high for 50 of every 100 cycles; power_level=12 -> high for 100 of 100.
